serial_tx_piso: RTL and testbench
=================================

# serial_tx_piso

Parallel-in serial-out frame transmitter built on the team's positive-edge flip-flop primitives. It accepts a parallel word through a load/ready handshake and serialises it on a single line: start bit, data LSB first, optional parity bit, stop bit. Each bit is held for a fixed number of clock cycles. It is the transmit end of the team's serial link, the counterpart to the serial-in parallel-out receiver.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..16.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held; minimum 1.

- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  request to start a frame with data_in.
- ready  output  1  high only in IDLE; a load is accepted only while ready=1.
- tx_out  output  1  serial line, registered; idles high.
- busy  output  1  high from the accept edge until the return to IDLE; equals ~ready.
- done  output  1  one-cycle pulse during the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
- Reset, asynchronous: state=IDLE, tx_out=1, ready=1, busy=0, done=0. The shift register, bit counter and cycle counter all clear to 0.
- IDLE: tx_out=1.
  - On a rising edge with load=1, the word is accepted: data_in is captured into the shift register, the cycle counter is set to 0, state goes to START and tx_out goes to 0 on the same edge.
  - load=0 keeps the block in IDLE.
- START: tx_out=0 for CLKS_PER_BIT cycles, then state goes to DATA with tx_out=shreg[0] and bit index 0.
- DATA: tx_out carries the current LSB of the shift register.
  - After CLKS_PER_BIT cycles the register shifts right by 1 and the bit index increments.
  - After bit WIDTH-1, state goes to PARITY if PARITY_EN is defined, otherwise to STOP.
- PARITY: tx_out holds the even-parity bit, the XOR of the captured word, for CLKS_PER_BIT cycles, then state goes to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. done=1 during the last of these cycles. The next edge returns to IDLE.
- Cycle counter: width $clog2(CLKS_PER_BIT), minimum 1 bit. It wraps to 0 at each bit boundary.
- Bit index: width $clog2(WIDTH). It never exceeds WIDTH-1.
- Parity is computed from the captured copy of the word, not from live data_in.

## Timing
- Frame length F = (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT with PARITY_EN. This counts from the accept edge to the edge that returns to IDLE.
- Latency: the start bit appears on tx_out immediately after the accept edge.
- Back-to-back frames: holding load=1 gives a frame start every F+1 cycles, with exactly one idle cycle (tx_out=1) between frames.
- load asserted while busy=1 is ignored and not queued.
- data_in changes after the accept edge have no effect on the current frame.
- CLKS_PER_BIT=1: each bit lasts one cycle and done coincides with the single stop cycle.
- Reset asserted mid-frame: tx_out goes to 1 and state goes to IDLE immediately, without waiting for a clock edge. The partial frame is abandoned and done is not pulsed.
- Reset deasserted with load=1: the first accept occurs on the first rising edge after deassertion.

## Configuration
- PARITY_EN defined: the PARITY state is compiled in and an even-parity bit is inserted between the last data bit and the stop bit. F grows by CLKS_PER_BIT.
- PARITY_EN undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Test plan
All scenarios use WIDTH=8 and CLKS_PER_BIT=4.
- Reset, then idle 10 cycles -> tx_out=1, ready=1, busy=0, done=0 throughout.
- load=1 with data_in=0xA5, no PARITY_EN -> tx_out reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (F=40). done is high only on cycle 40; ready returns on the next edge.
- PARITY_EN with data_in=0x07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop (F=44). With 0xA5 the parity bit is 0.
- load held high with data_in=0x3C then 0xFF -> frames start 41 cycles apart with one idle-high cycle between them. A load pulse mid-frame with 0x00 is ignored.
- Reset pulsed during data bit 3 of 0xA5 -> tx_out=1 and ready=1 asynchronously, no done pulse. A later load of 0x5A produces a clean full frame.
- data_in toggled every cycle after accepting 0x81 -> serial output is still 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define PARITY_EN to compile in the parity bit between the last data bit and the stop bit.
module serial_tx_piso #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             tx_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bitIdx;
   logic [CW-1:0]    cnt;
`ifdef PARITY_EN
   logic             parity;
`endif

   assign busy = ~ready;

   // Frame sequencer; tx_out always reflects the bit of the state being entered,
   // so the line changes on the same edge as the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         tx_out <= 1'b1;
         ready  <= 1'b1;
         done   <= 1'b0;
         shreg  <= '0;
         bitIdx <= '0;
         cnt    <= '0;
`ifdef PARITY_EN
         parity <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx_out <= 1'b1;
               if (load) begin
                  shreg  <= data_in;
                  cnt    <= '0;
                  bitIdx <= '0;
                  state  <= START;
                  tx_out <= 1'b0;
                  ready  <= 1'b0;
`ifdef PARITY_EN
                  parity <= ^data_in;
`endif
               end
            end
            START: begin
               if (cnt == LAST_CNT) begin
                  cnt    <= '0;
                  bitIdx <= '0;
                  state  <= DATA;
                  tx_out <= shreg[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (bitIdx == LAST_BIT) begin
`ifdef PARITY_EN
                     state  <= PARITY;
                     tx_out <= parity;
`else
                     state  <= STOP;
                     tx_out <= 1'b1;
                     done   <= (CLKS_PER_BIT == 1);
`endif
                  end else begin
                     shreg  <= shreg >> 1;
                     bitIdx <= bitIdx + 1'b1;
                     tx_out <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef PARITY_EN
            PARITY: begin
               if (cnt == LAST_CNT) begin
                  cnt    <= '0;
                  state  <= STOP;
                  tx_out <= 1'b1;
                  done   <= (CLKS_PER_BIT == 1);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               tx_out <= 1'b1;
               if (cnt == LAST_CNT) begin
                  cnt   <= '0;
                  state <= IDLE;
                  ready <= 1'b1;
               end else begin
                  cnt  <= cnt + 1'b1;
                  done <= ((cnt + 1'b1) == LAST_CNT);
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= 1'b1;
               ready  <= 1'b1;
               cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Self-checking bench for serial_tx_piso: table vectors, corner sequences and random words
// compared against a frame model that builds the expected line bit by bit from the word.
module tb_serial_tx_piso;

   localparam int W = 8;
   localparam int C = 4;
`ifdef PARITY_EN
   localparam int F = (W + 3) * C;
`else
   localparam int F = (W + 2) * C;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] data_in = '0;
   logic         load = 1'b0;
   logic         ready, tx_out, busy, done;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         par;
      bit           toggle;
      bit           pulse;
   } vec_t;

   vec_t vecs[4];

   serial_tx_piso #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
      .clock   (clock),
      .reset   (reset),
      .data_in (data_in),
      .load    (load),
      .ready   (ready),
      .tx_out  (tx_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clock = ~clock;

   // Expected line value for bit slot idx of a frame carrying word w.
   function automatic logic expBit(input logic [W-1:0] w, input logic p, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= W) return w[idx-1];
`ifdef PARITY_EN
      if (idx == W + 1) return p;
`endif
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Called at a negedge while idle; the accept happens on the following posedge.
   task automatic applyStimulus(input logic [W-1:0] w);
      load    = 1'b1;
      data_in = w;
      @(posedge clock);
   endtask

   // Walks one full frame from the accept edge, then checks the idle cycle after it.
   task automatic checkFrame(input logic [W-1:0] w, input logic p, input bit holdLoad,
                             input bit toggle, input bit pulse);
      for (int k = 1; k <= F; k++) begin
         @(negedge clock);
         checkOutput($sformatf("tx cyc%0d", k), tx_out, expBit(w, p, (k - 1) / C));
         checkOutput($sformatf("done cyc%0d", k), done, k == F);
         if (k == 1 || k == F) begin
            checkOutput("busy in frame", busy, 1'b1);
            checkOutput("ready in frame", ready, 1'b0);
         end
         load = holdLoad || (pulse && k == 15);
         if (toggle) data_in = ~data_in;
         else if (pulse && k == 15) data_in = '0;
      end
      @(negedge clock);
      checkOutput("tx idle after", tx_out, 1'b1);
      checkOutput("ready idle after", ready, 1'b1);
      checkOutput("busy idle after", busy, 1'b0);
      checkOutput("done idle after", done, 1'b0);
   endtask

   initial begin
      logic [W-1:0] rw;

      vecs[0] = '{data: 8'hA5, par: 1'b0, toggle: 1'b0, pulse: 1'b0};
      vecs[1] = '{data: 8'h07, par: 1'b1, toggle: 1'b0, pulse: 1'b0};
      vecs[2] = '{data: 8'h81, par: 1'b0, toggle: 1'b1, pulse: 1'b0};
      vecs[3] = '{data: 8'h5A, par: 1'b0, toggle: 1'b0, pulse: 1'b1};

      repeat (2) @(negedge clock);
      checkOutput("reset tx", tx_out, 1'b1);
      checkOutput("reset ready", ready, 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checkOutput("idle tx", tx_out, 1'b1);
         checkOutput("idle ready", ready, 1'b1);
         checkOutput("idle busy", busy, 1'b0);
         checkOutput("idle done", done, 1'b0);
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].data);
         checkFrame(vecs[i].data, vecs[i].par, 1'b0, vecs[i].toggle, vecs[i].pulse);
      end

      // Held load: two frames separated by exactly one idle cycle.
      applyStimulus(8'h3C);
      checkFrame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'hFF);
      checkFrame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during data bit 3, released with load already high.
      applyStimulus(8'hA5);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clock);
         load = 1'b0;
      end
      checkOutput("bit3 before reset", tx_out, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset tx", tx_out, 1'b1);
      checkOutput("async reset ready", ready, 1'b1);
      checkOutput("async reset busy", busy, 1'b0);
      checkOutput("async reset done", done, 1'b0);
      @(negedge clock);
      checkOutput("reset hold done", done, 1'b0);
      reset   = 1'b0;
      load    = 1'b1;
      data_in = 8'h5A;
      @(posedge clock);
      checkFrame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clock);
         rw = W'($urandom);
         applyStimulus(rw);
         checkFrame(rw, ^rw, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
